// File: rtl/fpu_pkg.sv
// Shared FPU definitions: widths, normalizer states and mantissa field positions.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Bit positions inside the 28-bit normalized mantissa, shared with rounding.
    localparam int MANT_HIDDEN_POS = 27;
    localparam int MANT_GUARD_POS  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/unit_lzc28.sv
// Combinational leading-zero counter for a 28-bit vector.
// Count is 28 when the input is all zeros; o_zero flags that case.
module unit_lzc28 (
    input  logic [27:0] i_vec,
    output logic [4:0]  o_cnt,
    output logic        o_zero
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            o_cnt = i_vec[i] ? 5'(27 - i) : o_cnt;
        end
        o_zero = (i_vec == 28'd0);
    end

endmodule

// File: rtl/unit_normalize_seq.sv
// Iterative post-add/sub normalizer feeding the FPU rounding stage.
// Right-shifts a carry out by one, or left-shifts by up to STEP bits per
// cycle until the hidden bit sits at [27], tracking the exponent in EXP_W+1
// bits so underflow/overflow never wraps.
import fpu_pkg::*;

module unit_normalize_seq #(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int MANT_W = fpu_pkg::MANT_W,
    parameter int STEP   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W:0]   i_mant,
    input  logic              i_ov_fl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_ov_fl,
    output logic              o_un_fl,
    output logic              o_zero
);

    localparam logic [EXP_W-1:0] EXP_ONES    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_PRE_MAX = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [4:0]       STEP_5      = 5'(STEP);

    norm_state_t       state_q, state_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic              valid_q, valid_d;
    logic              ov_q, ov_d;
    logic              un_q, un_d;
    logic              zero_q, zero_d;

    logic [4:0]        lz_s;
    logic              lz_zero_s;
    logic [4:0]        k_s;
    logic [EXP_W:0]    k_ext_s;
    logic [MANT_W-1:0] mant_shl_s;

    unit_lzc28 u_lzc (
        .i_vec  (mant_q),
        .o_cnt  (lz_s),
        .o_zero (lz_zero_s)
    );

    // Per-cycle shift distance: leading zeros capped at STEP.
    always_comb begin
        if (lz_s > STEP_5) begin
            k_s = STEP_5;
        end else begin
            k_s = lz_s;
        end
        k_ext_s    = {{(EXP_W-4){1'b0}}, k_s};
        mant_shl_s = mant_q << k_s;
    end

    // Next-state, datapath and flag computation for capture, shift and hold.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        valid_d = valid_q;
        ov_d    = ov_q;
        un_d    = un_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    ov_d    = 1'b0;
                    un_d    = 1'b0;
                    zero_d  = 1'b0;
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (i_ov_fl || (i_exp == EXP_ONES)) begin
                        exp_d  = {1'b0, EXP_ONES};
                        mant_d = '0;
                        ov_d   = 1'b1;
                    end else if (i_mant == '0) begin
                        exp_d  = '0;
                        mant_d = '0;
                        zero_d = 1'b1;
                    end else if (i_mant[MANT_W]) begin
                        if (i_exp == EXP_PRE_MAX) begin
                            exp_d  = {1'b0, EXP_ONES};
                            mant_d = '0;
                            ov_d   = 1'b1;
                        end else begin
                            // Fold the dropped LSB into sticky so rounding still sees it.
                            exp_d  = {1'b0, i_exp} + {{EXP_W{1'b0}}, 1'b1};
                            mant_d = {i_mant[MANT_W:2], i_mant[1] | i_mant[0]};
                        end
                    end else if (i_mant[MANT_W-1]) begin
                        exp_d  = {1'b0, i_exp};
                        mant_d = i_mant[MANT_W-1:0];
                    end else begin
                        exp_d   = {1'b0, i_exp};
                        mant_d  = i_mant[MANT_W-1:0];
                        state_d = SHIFT;
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (lz_zero_s || (exp_q <= k_ext_s)) begin
                    exp_d   = '0;
                    mant_d  = '0;
                    un_d    = 1'b1;
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    exp_d  = exp_q - k_ext_s;
                    mant_d = mant_shl_s;
                    if (mant_shl_s[MANT_HIDDEN_POS]) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            mant_q  <= '0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = valid_q;
    assign o_exp   = exp_q[EXP_W-1:0];
    assign o_mant  = mant_q;
    assign o_ov_fl = ov_q;
    assign o_un_fl = un_q;
    assign o_zero  = zero_q;

endmodule

// File: doc/unit_normalize_seq.md
Name: unit_normalize_seq

Overview:
- Iterative post-add/sub normalizer directly upstream of the FPU rounding stage.
- Takes a raw exponent and a 29-bit pre-normalized mantissa (carry, hidden, fraction, guard/round/sticky).
- Produces an 8-bit exponent and a 28-bit mantissa with the hidden bit at [27], fraction [26:4], guard [3] and round/sticky [2:0], plus ov/un flags in the format rounding consumes.
- Left shifts are performed up to STEP bits per cycle behind a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 28, output mantissa width; input is MANT_W+1.
- STEP, 4, maximum left-shift distance per cycle (1..27).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream operand valid.
- o_ready  out  1  block can accept an operand.
- i_exp  in  8  unnormalized biased exponent.
- i_mant  in  29  raw mantissa; [28] carry, [27] hidden position, [1:0] sticky bits.
- i_ov_fl  in  1  upstream overflow already detected.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_exp  out  8  normalized exponent.
- o_mant  out  28  normalized mantissa.
- o_ov_fl  out  1  exponent overflow.
- o_un_fl  out  1  exponent underflow; result flushed to zero.
- o_zero  out  1  exact-zero mantissa input.

Behaviour:
- Reset (synchronous, i_rst_n low at an i_clk edge): state IDLE; o_valid, o_exp, o_mant, o_ov_fl, o_un_fl and o_zero all 0. Reset mid-SHIFT or mid-DONE aborts the operation and no result is ever presented.
- States: IDLE, SHIFT, DONE. o_ready = (state == IDLE). Throughput is at most one result per 2 cycles.
- IDLE, on an edge with i_valid=1, capture and classify in priority order:
  - a) i_ov_fl=1 or i_exp=8'hFF: exp=FF, mant=0, ov=1 -> DONE.
  - b) i_mant==0: exp=0, mant=0, zero=1 -> DONE.
  - c) i_mant[28]=1: mant = {i_mant[28:2], i_mant[1]|i_mant[0]}, which keeps sticky. exp = i_exp+1. If i_exp==8'hFE: exp=FF, mant=0, ov=1 -> DONE.
  - d) i_mant[27]=1: mant = i_mant[27:0], exp = i_exp -> DONE.
  - e) otherwise: mant_reg = i_mant[27:0], exp_reg = i_exp -> SHIFT.
- SHIFT, each cycle:
  - lz = leading-zero count of mant_reg (1..27); k = min(lz, STEP).
  - If exp_reg <= k: flush to zero with un=1, exp=0, mant=0 -> DONE.
  - Else: exp_reg -= k, mant_reg <<= k (zero-fill LSBs). Go to DONE when the new [27]=1, otherwise stay in SHIFT.
- Latency: o_valid rises 1 cycle after the accepting edge for cases a–d, and 1+ceil(lz/STEP) cycles after for case e (absent underflow).
- DONE:
  - o_valid=1; all outputs are registered and held stable until the edge where i_ready=1, which returns to IDLE and clears o_valid.
  - No new operand is accepted in DONE, even when i_ready=1 in the same cycle.
- Flag exclusivity: at most one of o_ov_fl, o_un_fl, o_zero is set per result. All flags are cleared on each new capture.
- Exponent arithmetic is done in EXP_W+1 bits internally; no wrap-around is visible at the outputs.

Decomposition:
- Package fpu_pkg holds:
  - EXP_W, MANT_W, EXP_MAX = 8'hFF;
  - the norm_state_t enum {IDLE, SHIFT, DONE};
  - the mantissa field-position constants (hidden 27, guard 3), shared with rounding.
- One sub-module: unit_lzc28, a combinational 28-bit leading-zero counter with a 5-bit count and an all-zero flag.

Test Plan:
- Already normalized: i_exp=8'h80, i_mant=29'h0800_0000 -> o_valid after 1 cycle; o_exp=8'h80, o_mant=28'h800_0000, all flags 0.
- Carry right-shift with sticky: i_exp=8'h7F, i_mant=29'h1000_0003 -> o_exp=8'h80, o_mant=28'h800_0001.
- Multi-cycle left shift, STEP=4: i_exp=8'h80, i_mant=29'h0000_0010 (lz=23) -> o_valid 7 cycles after accept; o_exp=8'h69, o_mant=28'h800_0000; o_ready=0 throughout.
- Underflow: i_exp=8'h03, i_mant=29'h0000_0100 -> o_un_fl=1, o_exp=0, o_mant=0, o_valid 2 cycles after accept.
- Overflow: i_exp=8'hFE with i_mant[28]=1 -> o_ov_fl=1, o_exp=8'hFF, o_mant=0. Separately, i_ov_fl=1 with any operand -> same result.
- Handshake, zero and reset:
  - Hold i_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0.
  - i_mant=0 -> o_zero=1, o_exp=0.
  - Drop i_rst_n during SHIFT -> next cycle o_valid=0, o_ready=1, all outputs 0.
